cycle_count_display: RTL and testbench
======================================

# cycle_count_display

Board-level display consumer for the Sobel run statistics. It watches the `done` / `total_cycles` pair exported by the Sobel wrapper and captures the cycle count on the rising edge of `done`. It converts the count to decimal with a sequential double-dabble engine (one bit per clock) and drives the six active-low DE1-SoC seven-segment displays. The block instantiates in `top.sv` next to the Sobel wrapper.

## Interface

Parameters:
- `CNT_W`, 32: width of the captured cycle count.
- `BCD_DIGITS`, 10: decimal digits produced. Ten digits cover 2^32−1.

Ports:
- `clk`  in  1: single system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `done_in`  in  1: Sobel completion level. Only its rising edge is used.
- `total_cycles_in`  in  CNT_W: cycle count, sampled on the clock edge that detects the `done_in` rising edge.
- `page_sel`  in  1: 0 shows decimal digits 5..0; 1 shows decimal digits 9..6.
- `busy`  out  1: conversion in progress.
- `valid`  out  1: display holds a converted result.
- `hex0`..`hex5`  out  7 each: active-low segments, bit0 = a … bit6 = g; `hex0` is the rightmost display.

## Operation

- Edge detect: `done_q` registers `done_in`. A start request is `done_in & ~done_q`.
- FSM has two states, IDLE and CONVERT.
  - IDLE → CONVERT on a start request:
    - load `total_cycles_in` into the shift register;
    - clear the BCD accumulator (4×BCD_DIGITS bits);
    - set the bit counter to 0;
    - set `busy` = 1.
  - CONVERT, each cycle:
    - every BCD nibble ≥ 5 gets +3;
    - then shift {bcd, shreg} left by 1;
    - increment the counter.
  - CONVERT exit, when the counter reaches CNT_W−1:
    - copy the final BCD into the display register;
    - set `valid` = 1 and `busy` = 0;
    - return to IDLE.
- Start requests while in CONVERT are ignored (dropped, not queued). `done_q` keeps tracking `done_in`.
- A falling edge or a held level of `done_in` has no effect. The display keeps the last result.
- Digit mapping:
  - `page_sel` = 0: `hexN` shows digit N.
  - `page_sel` = 1: `hex0`..`hex3` show digits 6..9; `hex4` and `hex5` are blank.
- Segment codes:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19;
  - 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10;
  - blank = 7'h7F.
- While `valid` = 0, all hex outputs are blank.
- Reset, including mid-conversion:
  - state = IDLE;
  - `busy` = 0, `valid` = 0;
  - shift, BCD and display registers = 0;
  - `done_q` = 0;
  - all `hexN` = 7'h7F.

## Timing

- Let k be the clock edge where `done_in` = 1 and `done_q` = 0.
  - `busy` goes high after edge k.
  - CONVERT occupies edges k+1..k+32.
  - After edge k+32: `valid` = 1, `busy` = 0.
  - Hex outputs are registered, so the new value is visible after edge k+33.
- Start-to-display latency is 33 cycles for CNT_W = 32; in general it is CNT_W+1.
- A `page_sel` change appears on the hex outputs one clock later.
- A new start request is accepted at the earliest on edge k+33.

## Configuration

- `CYCLE_DISPLAY_LZB_EN` (leading-zero blanking).
  - Defined: digit i (global index) is blanked when digits i..BCD_DIGITS−1 are all zero and i ≠ 0. Digit 0 is always shown.
  - Undefined: every digit shows its numeral, including leading zeros.
  - The macro has no other effect on behaviour or timing.

## Test plan

- Reset → all `hexN` = 7'h7F, `busy` = 0, `valid` = 0. Blanking still holds while `done_in` is held high through reset.
- `total_cycles_in` = 12345, `done_in` rises at edge k:
  - `busy` is high for edges k+1..k+32;
  - after edge k+33: `hex0..hex4` = 7'h12, 7'h19, 7'h30, 7'h24, 7'h79;
  - `hex5` = 7'h7F with LZB, 7'h40 without.
- `total_cycles_in` = 4294967295:
  - `page_sel` = 0: `hex0..hex5` = 7'h12, 7'h10, 7'h24, 7'h78, 7'h02, 7'h10;
  - `page_sel` = 1: `hex0..hex3` = 7'h19, 7'h10, 7'h24, 7'h19 and `hex4`/`hex5` = 7'h7F, one cycle after the switch.
- `total_cycles_in` = 0:
  - `hex0` = 7'h40;
  - `hex1..hex5` = 7'h7F with LZB, all 7'h40 without;
  - with `page_sel` = 1 and LZB, `hex0..hex3` are blank.
- Convert 100, then pulse `done_in` low→high again at k+10 with input 999 → the pulse is ignored and the display shows 100.
  - Then assert `rst` at k'+10 of a fresh conversion → all hex outputs are 7'h7F immediately, and `valid` = 0.

Source files
------------

// File: rtl/cycle_count_display.sv
// rtl/cycle_count_display.sv - captures Sobel cycle count, double-dabble to BCD, drives six 7-seg displays.
// Optional leading-zero blanking: define CYCLE_DISPLAY_LZB_EN.
module cycle_count_display #(
  parameter int CNT_W      = 32,
  parameter int BCD_DIGITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_in,
  input  logic [CNT_W-1:0] total_cycles_in,
  input  logic             page_sel,
  output logic             busy,
  output logic             valid,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic [6:0]       hex5
);

  localparam int BW = 4 * BCD_DIGITS;
  localparam int CW = $clog2(CNT_W);

  typedef enum logic {S_IDLE, S_CONVERT} state_t;

  state_t                r_state, w_state_next;
  logic                  r_done_q;
  logic [CNT_W-1:0]      r_shreg;
  logic [BW-1:0]         r_bcd, r_disp, w_bcd_adj;
  logic [BW+CNT_W-1:0]   w_cat;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy, r_valid;
  logic                  w_start, w_last;
  logic [BCD_DIGITS-1:0] w_blank;
  logic [6:0]            r_hex [6];
  logic [6:0]            w_hex [6];

  function automatic logic [6:0] seg(input logic [3:0] d, input logic blank);
    if (blank) return 7'h7F;
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_start      = done_in & ~r_done_q;
    w_last       = (r_cnt == CW'(CNT_W - 1));
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_state_next = S_CONVERT;
      S_CONVERT: if (w_last)  w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_cat = {w_bcd_adj, r_shreg} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q <= 1'b0;
      r_shreg  <= '0;
      r_bcd    <= '0;
      r_disp   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_done_q <= done_in;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_shreg <= total_cycles_in;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CONVERT: begin
          r_bcd   <= w_cat[BW+CNT_W-1:CNT_W];
          r_shreg <= w_cat[CNT_W-1:0];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_disp  <= w_cat[BW+CNT_W-1:CNT_W];
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CYCLE_DISPLAY_LZB_EN
  always_comb begin
    logic v_zero_run;
    v_zero_run = 1'b1;
    w_blank    = '0;
    // Scan from the most significant digit; digit 0 is never blanked.
    for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
      v_zero_run = v_zero_run & (r_disp[4*i +: 4] == 4'd0);
      w_blank[i] = v_zero_run && (i != 0);
    end
  end
`else
  always_comb w_blank = '0;
`endif

  always_comb begin
    for (int n = 0; n < 6; n++) begin
      w_hex[n] = 7'h7F;
      if (r_valid) begin
        if (!page_sel)  w_hex[n] = seg(r_disp[4*n +: 4], w_blank[n]);
        else if (n < 4) w_hex[n] = seg(r_disp[4*(n+6) +: 4], w_blank[n+6]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 6; n++) r_hex[n] <= 7'h7F;
    end else begin
      for (int n = 0; n < 6; n++) r_hex[n] <= w_hex[n];
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign hex0  = r_hex[0];
  assign hex1  = r_hex[1];
  assign hex2  = r_hex[2];
  assign hex3  = r_hex[3];
  assign hex4  = r_hex[4];
  assign hex5  = r_hex[5];

endmodule

// File: tb/tb_cycle_count_display.sv
// tb/tb_cycle_count_display.sv - scoreboard bench for cycle_count_display (honours CYCLE_DISPLAY_LZB_EN).
module tb_cycle_count_display;

  logic        clk = 1'b0;
  logic        rst, done_in, page_sel;
  logic [31:0] total;
  logic        busy, valid;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  cycle_count_display #(.CNT_W(32), .BCD_DIGITS(10)) dut (
    .clk(clk), .rst(rst), .done_in(done_in), .total_cycles_in(total),
    .page_sel(page_sel), .busy(busy), .valid(valid),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef CYCLE_DISPLAY_LZB_EN
  localparam logic [6:0] Z = 7'h7F;
`else
  localparam logic [6:0] Z = 7'h40;
`endif
  localparam logic [6:0] B = 7'h7F;

  typedef struct {
    int          cyc;
    string       name;
    bit          chk_hex;
    logic [41:0] hexv;
    bit          chk_bv;
    logic        busy;
    logic        valid;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [41:0] hx(input logic [6:0] h5, h4, h3, h2, h1, h0);
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  task automatic push_hex(input int c, input string nm, input logic [41:0] v);
    exp_t e;
    e.cyc = c; e.name = nm; e.chk_hex = 1'b1; e.hexv = v;
    e.chk_bv = 1'b0; e.busy = 1'b0; e.valid = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_bv(input int c, input string nm, input logic b, input logic v);
    exp_t e;
    e.cyc = c; e.name = nm; e.chk_hex = 1'b0; e.hexv = '0;
    e.chk_bv = 1'b1; e.busy = b; e.valid = v;
    q.push_back(e);
  endtask

  // Monitor: pops every expectation whose cycle has arrived and compares outputs.
  always @(negedge clk) begin
    exp_t        e;
    logic [41:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = {hex5, hex4, hex3, hex2, hex1, hex0};
      if (e.cyc != cyc) begin
        n_tests++; n_fail++;
        $display("FAIL %s missed: due cycle %0d, now %0d", e.name, e.cyc, cyc);
      end else begin
        if (e.chk_hex) begin
          n_tests++;
          if (act !== e.hexv) begin
            n_fail++;
            $display("FAIL %s hex5..hex0 actual=%h required=%h", e.name, act, e.hexv);
          end
        end
        if (e.chk_bv) begin
          n_tests++;
          if ({busy, valid} !== {e.busy, e.valid}) begin
            n_fail++;
            $display("FAIL %s busy/valid actual=%b%b required=%b%b", e.name, busy, valid, e.busy, e.valid);
          end
        end
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_conv(input logic [31:0] v, output int k);
    total   = v;
    done_in = 1'b1;
    k       = cyc + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int c;
    rst = 1'b1; done_in = 1'b1; page_sel = 1'b0; total = 32'd7;
    @(negedge clk);
    push_hex(cyc + 1, "rst_hex", hx(B, B, B, B, B, B));
    push_bv (cyc + 1, "rst_bv", 1'b0, 1'b0);
    push_hex(cyc + 3, "rst_hold_hex", hx(B, B, B, B, B, B));
    wait_to(cyc + 4);
    done_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    start_conv(32'd12345, k);
    push_bv (k,      "c12345_busy_k",   1'b1, 1'b0);
    push_bv (k + 31, "c12345_busy_k31", 1'b1, 1'b0);
    push_hex(k + 32, "c12345_hex_k32",  hx(B, B, B, B, B, B));
    push_bv (k + 32, "c12345_done_k32", 1'b0, 1'b1);
    push_hex(k + 33, "c12345_hex",      hx(Z, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12));
    wait_to(k + 2); done_in = 1'b0;
    wait_to(k + 34);

    start_conv(32'd4294967295, k);
    push_hex(k + 33, "cmax_p0",      hx(7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12));
    push_hex(k + 34, "cmax_p0_hold", hx(7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12));
    wait_to(k + 2); done_in = 1'b0;
    wait_to(k + 34);
    page_sel = 1'b1;
    push_hex(k + 35, "cmax_p1", hx(B, B, 7'h19, 7'h24, 7'h10, 7'h19));
    wait_to(k + 35); page_sel = 1'b0;
    wait_to(k + 37);

    start_conv(32'd0, k);
    push_hex(k + 33, "czero_p0", hx(Z, Z, Z, Z, Z, 7'h40));
    wait_to(k + 2); done_in = 1'b0;
    wait_to(k + 33);
    page_sel = 1'b1;
    push_hex(k + 34, "czero_p1", hx(B, B, Z, Z, Z, Z));
    wait_to(k + 34); page_sel = 1'b0;
    wait_to(k + 36);

    start_conv(32'd100, k);
    push_bv (k + 32, "c100_bv",        1'b0, 1'b1);
    push_hex(k + 33, "c100_hex",       hx(Z, Z, Z, 7'h79, 7'h40, 7'h40));
    push_hex(k + 40, "c100_hold_hex",  hx(Z, Z, Z, 7'h79, 7'h40, 7'h40));
    push_bv (k + 40, "c100_hold_bv",   1'b0, 1'b1);
    wait_to(k + 8); done_in = 1'b0;
    wait_to(k + 9); done_in = 1'b1; total = 32'd999;
    wait_to(k + 41); done_in = 1'b0;
    wait_to(k + 42);

    start_conv(32'd555, k);
    push_hex(k + 9, "pre_rst_hex", hx(Z, Z, Z, 7'h79, 7'h40, 7'h40));
    push_bv (k + 9, "pre_rst_bv",  1'b1, 1'b1);
    wait_to(k + 2); done_in = 1'b0;
    wait_to(k + 9);
    @(posedge clk); #1;
    rst = 1'b1;
    push_hex(cyc, "rst_mid_hex", hx(B, B, B, B, B, B));
    push_bv (cyc, "rst_mid_bv",  1'b0, 1'b0);
    @(negedge clk);
    c = cyc;
    push_hex(c + 1, "rst_mid_hold_hex", hx(B, B, B, B, B, B));
    @(negedge clk); rst = 1'b0;
    push_bv (c + 4, "post_rst_bv",  1'b0, 1'b0);
    push_hex(c + 4, "post_rst_hex", hx(B, B, B, B, B, B));
    wait_to(c + 8);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++; n_fail++;
      $display("FAIL %s never checked: due cycle %0d", e.name, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
